store_merge_unit: RTL and testbench

//  Store-side counterpart of the load sign-extension path: narrows CPU store data
//  (SB/SH/SW) into the correct byte lanes of a 32-bit word. Sits between the MEM

---
 rtl/store_merge_unit_if.sv | 28 ++
 rtl/store_merge_unit.sv | 120 ++++++++++++
 tb/tb_store_merge_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_merge_unit_if.sv
// Store request port plus word-wide RAM port of the store merge unit.
// slave = the merge unit's view, master = requester/RAM side.
interface store_merge_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [31:0]       req_data;
    logic              done;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;

    modport master (
        output req_valid, req_addr, req_size, req_data, mem_rdata,
        input  req_ready, done, misaligned, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_data, mem_rdata,
        output req_ready, done, misaligned, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/store_merge_unit.sv
// Places SB/SH/SW store data into the byte lanes of a 32-bit RAM word without byte
// enables; sub-word stores use read-modify-write, aligned words are written directly.
module store_merge_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    store_merge_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_next;
    logic [1:0]        size_q, size_n;
    logic [1:0]        lo_q, lo_n;
    logic [15:0]       data_q, data_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [31:0]       mem_wdata_q, mem_wdata_n;
    logic              req_ready_q, done_q, misaligned_q, mem_rd_en_q, mem_wr_en_q;
    logic [1:0]        byte_lane;
    logic              half_lane;
    logic              illegal;
    logic [31:0]       merged;

    assign byte_lane = BIG_ENDIAN ? (2'd3 - lo_q) : lo_q;
    assign half_lane = BIG_ENDIAN ? ~lo_q[1] : lo_q[1];

    assign illegal = (bus.req_size == 2'b11)
                  || ((bus.req_size == 2'b01) && bus.req_addr[0])
                  || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    always_comb begin
        merged = bus.mem_rdata;
        case (size_q)
            2'b00:   merged[{byte_lane, 3'b000} +: 8]  = data_q[7:0];
            2'b01:   merged[{half_lane, 4'b0000} +: 16] = data_q;
            default: ;
        endcase
    end

    always_comb begin
        state_next  = state;
        size_n      = size_q;
        lo_n        = lo_q;
        data_n      = data_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    size_n     = bus.req_size;
                    lo_n       = bus.req_addr[1:0];
                    data_n     = bus.req_data[15:0];
                    mem_addr_n = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    if (illegal) begin
                        state_next = S_ERR;
                    end else if (bus.req_size == 2'b10) begin
                        state_next  = S_WRITE;
                        mem_wdata_n = bus.req_data;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_READ:  state_next = S_WAIT;
            S_WAIT: begin
                state_next  = S_WRITE;
                mem_wdata_n = merged;
            end
            S_WRITE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            size_q       <= '0;
            lo_q         <= '0;
            data_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            req_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
        end else begin
            state        <= state_next;
            size_q       <= size_n;
            lo_q         <= lo_n;
            data_q       <= data_n;
            mem_addr_q   <= mem_addr_n;
            mem_wdata_q  <= mem_wdata_n;
            req_ready_q  <= (state_next == S_IDLE);
            done_q       <= (state_next == S_DONE) || (state_next == S_ERR);
            misaligned_q <= (state_next == S_ERR);
            mem_rd_en_q  <= (state_next == S_READ);
            mem_wr_en_q  <= (state_next == S_WRITE);
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.done       = done_q;
    assign bus.misaligned = misaligned_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: little- and big-endian instances share one request
// stream and one RAM stub; a scoreboard checks each completion.
module tb_store_merge_unit;
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] exp_le;
        logic [31:0] exp_be;
    } vec_t;

    typedef struct {
        int          id;
        int          ta;
        logic        mis;
        logic        word;
        logic        sub;
        logic [31:0] waddr;
        logic [31:0] exp_le;
        logic [31:0] exp_be;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   prev_ta = 0;
    int   tot_wr = 0;
    int   tot_done = 0;

    vec_t        tbl[13];
    exp_t        q[$];
    logic [31:0] ram_init[64];

    int          rd_seen, wr_seen, rd_cyc, wr_cyc;
    logic        overlap;
    logic [31:0] wr_addr, wr_le, wr_be;
    exp_t        e;

    store_merge_unit_if #(.ADDR_W(32)) bus ();
    store_merge_unit_if #(.ADDR_W(32)) be_bus ();

    store_merge_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .rst_n(rst_n), .bus(bus));
    store_merge_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .rst_n(rst_n), .bus(be_bus));

    assign be_bus.req_valid = bus.req_valid;
    assign be_bus.req_addr  = bus.req_addr;
    assign be_bus.req_size  = bus.req_size;
    assign be_bus.req_data  = bus.req_data;
    assign be_bus.mem_rdata = bus.mem_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM stub: returns the word preloaded for the address, one cycle after the strobe.
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= ram_init[bus.mem_addr[7:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    endtask

    function automatic int lat_of(input vec_t v);
        if (v.mis) return 1;
        if (v.size == 2'b10) return 2;
        return 4;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_seen = 0;
            wr_seen = 0;
            overlap = 1'b0;
        end else begin
            if (bus.mem_rd_en && bus.mem_wr_en) overlap = 1'b1;
            if (bus.mem_rd_en) begin
                rd_seen++;
                rd_cyc = cyc;
            end
            if (bus.mem_wr_en) begin
                wr_seen++;
                tot_wr++;
                wr_cyc  = cyc;
                wr_addr = bus.mem_addr;
                wr_le   = bus.mem_wdata;
            end
            if (be_bus.mem_wr_en) wr_be = be_bus.mem_wdata;
            if (bus.done) begin
                tot_done++;
                if (q.size() == 0) begin
                    chk("unexpected_done", {31'b0, bus.done}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("r%0d_misaligned", e.id), {31'b0, bus.misaligned}, {31'b0, e.mis});
                    chk($sformatf("r%0d_be_done", e.id), {31'b0, be_bus.done}, 32'd1);
                    chk($sformatf("r%0d_be_misaligned", e.id), {31'b0, be_bus.misaligned}, {31'b0, e.mis});
                    chk($sformatf("r%0d_done_lat", e.id), cyc - e.ta + 1, e.mis ? 1 : (e.word ? 2 : 4));
                    chk($sformatf("r%0d_wr_count", e.id), wr_seen, e.mis ? 0 : 1);
                    chk($sformatf("r%0d_rd_count", e.id), rd_seen, e.sub ? 1 : 0);
                    chk($sformatf("r%0d_rd_wr_overlap", e.id), {31'b0, overlap}, 32'd0);
                    if (!e.mis) begin
                        chk($sformatf("r%0d_wr_lat", e.id), wr_cyc - e.ta + 1, e.word ? 1 : 3);
                        chk($sformatf("r%0d_wr_addr", e.id), wr_addr, e.waddr);
                        chk($sformatf("r%0d_wdata_le", e.id), wr_le, e.exp_le);
                        chk($sformatf("r%0d_wdata_be", e.id), wr_be, e.exp_be);
                    end
                    if (e.sub) chk($sformatf("r%0d_rd_lat", e.id), rd_cyc - e.ta + 1, 1);
                end
                rd_seen = 0;
                wr_seen = 0;
                overlap = 1'b0;
            end
        end
    end

    task automatic drive_req(input int id, input bit push, input bit chk_gap, input int exp_gap);
        vec_t v;
        exp_t x;
        int   n;
        v = tbl[id];
        @(negedge clk);
        ram_init[v.addr[7:2]] = v.rdata;
        bus.req_addr  = v.addr;
        bus.req_size  = v.size;
        bus.req_data  = v.data;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("r%0d_accept", id), {31'b0, bus.req_ready}, 32'd1);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        if (chk_gap) chk($sformatf("r%0d_b2b_gap", id), cyc + 1 - prev_ta, exp_gap);
        prev_ta = cyc + 1;
        if (push) begin
            x.id     = id;
            x.ta     = cyc + 1;
            x.mis    = v.mis;
            x.word   = !v.mis && (v.size == 2'b10);
            x.sub    = !v.mis && (v.size != 2'b10);
            x.waddr  = {v.addr[31:2], 2'b00};
            x.exp_le = v.exp_le;
            x.exp_be = v.exp_be;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int wr_before, done_before;
        //            addr        size   data          rdata         mis   le            be
        tbl[0]  = '{32'h10, 2'b10, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1]  = '{32'h13, 2'b00, 32'h000000AA, 32'h11223344, 1'b0, 32'hAA223344, 32'h112233AA};
        tbl[2]  = '{32'h22, 2'b01, 32'hFFFFBEEF, 32'h11223344, 1'b0, 32'hBEEF3344, 32'h1122BEEF};
        tbl[3]  = '{32'h21, 2'b01, 32'h00001234, 32'h00000000, 1'b1, 32'h0, 32'h0};
        tbl[4]  = '{32'h02, 2'b10, 32'h12345678, 32'h00000000, 1'b1, 32'h0, 32'h0};
        tbl[5]  = '{32'h30, 2'b11, 32'h12345678, 32'h00000000, 1'b1, 32'h0, 32'h0};
        tbl[6]  = '{32'h2C, 2'b00, 32'h12345655, 32'hA0B0C0D0, 1'b0, 32'hA0B0C055, 32'h55B0C0D0};
        tbl[7]  = '{32'h15, 2'b00, 32'h00000077, 32'hA0B0C0D0, 1'b0, 32'hA0B077D0, 32'hA077C0D0};
        tbl[8]  = '{32'h1A, 2'b00, 32'h00000066, 32'hA0B0C0D0, 1'b0, 32'hA066C0D0, 32'hA0B066D0};
        tbl[9]  = '{32'h24, 2'b01, 32'h0000CAFE, 32'h55667788, 1'b0, 32'h5566CAFE, 32'hCAFE7788};
        tbl[10] = '{32'h3C, 2'b10, 32'h00000001, 32'h00000000, 1'b0, 32'h00000001, 32'h00000001};
        tbl[11] = '{32'h27, 2'b01, 32'h0000FFFF, 32'h00000000, 1'b1, 32'h0, 32'h0};
        tbl[12] = '{32'h1F, 2'b00, 32'h000000FF, 32'h00000000, 1'b0, 32'hFF000000, 32'h000000FF};

        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.req_data  = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_misaligned", {31'b0, bus.misaligned}, 32'd0);
        chk("reset_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
        chk("reset_wr_en", {31'b0, bus.mem_wr_en}, 32'd0);
        chk("reset_mem_addr", bus.mem_addr, 32'd0);
        chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            drive_req(i, 1'b1, 1'b0, 0);
            bus.req_valid = 1'b0;
            drain();
        end

        // Reset while the read-modify-write sits in WAIT: no write, no done.
        drive_req(1, 1'b0, 1'b0, 0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_before   = tot_wr;
        done_before = tot_done;
        rst_n = 1'b0;
        #1;
        chk("rst_wr_en", {31'b0, bus.mem_wr_en}, 32'd0);
        chk("rst_rd_en", {31'b0, bus.mem_rd_en}, 32'd0);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_write", tot_wr - wr_before, 0);
        chk("rst_no_done", tot_done - done_before, 0);
        chk("rst_ready_after", {31'b0, bus.req_ready}, 32'd1);
        drive_req(10, 1'b1, 1'b0, 0);
        bus.req_valid = 1'b0;
        drain();

        // Three stores with req_valid held high: each accepted only once idle again.
        wr_before   = tot_wr;
        done_before = tot_done;
        for (int i = 0; i < 3; i++)
            drive_req(i, 1'b1, i > 0, (i > 0) ? lat_of(tbl[i - 1]) + 1 : 0);
        bus.req_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("b2b_done_count", tot_done - done_before, 3);
        chk("b2b_wr_count", tot_wr - wr_before, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
        $fatal(1);
    end
endmodule
